// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge unit: store-type encodings,
// FSM state encoding and a small address helper.
package store_merge_unit_pkg;

  localparam logic [3:0] Type_SW  = 4'h8;
  localparam logic [3:0] Type_SB  = 4'h9;
  localparam logic [3:0] Type_SH  = 4'hA;
  localparam logic [3:0] Type_SWL = 4'hB;
  localparam logic [3:0] Type_SWR = 4'hC;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic is_store_type(input logic [3:0] store_type);
    return (store_type == Type_SW)  || (store_type == Type_SB) ||
           (store_type == Type_SH)  || (store_type == Type_SWL) ||
           (store_type == Type_SWR);
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Pipeline-side request/stall signals and word-RAM port of the store merge unit.
interface store_merge_unit_if;
  logic        EX_MEM_MemWrite;
  logic [3:0]  EX_MEM_StoreType;
  logic [31:0] EX_MEM_Addr;
  logic [31:0] EX_MEM_WriteData;
  logic        StoreStall;
  logic        StoreDone;
  logic [31:0] Mem_Addr;
  logic        Mem_Read;
  logic [31:0] Mem_ReadData;
  logic        Mem_Write;
  logic [31:0] Mem_WriteData;

  modport master (
    output EX_MEM_MemWrite, EX_MEM_StoreType, EX_MEM_Addr, EX_MEM_WriteData,
    output Mem_ReadData,
    input  StoreStall, StoreDone, Mem_Addr, Mem_Read, Mem_Write, Mem_WriteData
  );

  modport slave (
    input  EX_MEM_MemWrite, EX_MEM_StoreType, EX_MEM_Addr, EX_MEM_WriteData,
    input  Mem_ReadData,
    output StoreStall, StoreDone, Mem_Addr, Mem_Read, Mem_Write, Mem_WriteData
  );
endinterface

// File: rtl/store_merge_unit_merge.sv
// Combinational lane merge: write-side mirror of the load splitter.
module store_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] rt,
  input  logic [3:0]  store_type,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  // Overlay the rt lanes selected by store type and byte offset onto the old word
  always_comb begin
    merged = old_word;
    case (store_type)
      Type_SW:  merged = rt;
      Type_SB: begin
        case (lane)
          2'd0:    merged[7:0]   = rt[7:0];
          2'd1:    merged[15:8]  = rt[7:0];
          2'd2:    merged[23:16] = rt[7:0];
          2'd3:    merged[31:24] = rt[7:0];
          default: merged = old_word;
        endcase
      end
      Type_SH: begin
        if (lane[1]) merged[31:16] = rt[15:0];
        else         merged[15:0]  = rt[15:0];
      end
      Type_SWL: merged[31:16] = rt[31:16];
      Type_SWR: merged[15:0]  = rt[15:0];
      default:  merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store-side MEM-stage unit: SW writes directly, sub-word stores do a
// read-modify-write on the word-only RAM while the pipeline is stalled.
module store_merge_unit
  import store_merge_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  store_merge_unit_if.slave bus
);

  state_t      state, next_state;
  logic        accept;
  logic [31:0] data_q;
  logic [3:0]  type_q;
  logic [1:0]  lane_q;
  logic [31:0] merged;

  assign accept = (state == IDLE) && bus.EX_MEM_MemWrite;

  store_merge u_merge (
    .old_word   (bus.Mem_ReadData),
    .rt         (data_q),
    .store_type (type_q),
    .lane       (lane_q),
    .merged     (merged)
  );

  // Next-state logic and combinational stall
  always_comb begin
    next_state     = state;
    bus.StoreStall = 1'b0;
    case (state)
      IDLE: begin
        if (bus.EX_MEM_MemWrite) begin
          bus.StoreStall = 1'b1;
          if (bus.EX_MEM_StoreType == Type_SW)          next_state = WRITE;
          else if (is_store_type(bus.EX_MEM_StoreType)) next_state = READ;
          else                                          next_state = DONE;
        end else begin
          next_state = IDLE;
        end
      end
      READ: begin
        bus.StoreStall = 1'b1;
        next_state     = MERGE;
      end
      MERGE: begin
        bus.StoreStall = 1'b1;
        next_state     = WRITE;
      end
      WRITE: begin
        bus.StoreStall = 1'b1;
        next_state     = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Request latch; later states never look at the EX/MEM inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 32'h0000_0000;
      type_q <= 4'h0;
      lane_q <= 2'b00;
    end else if (accept) begin
      data_q <= bus.EX_MEM_WriteData;
      type_q <= bus.EX_MEM_StoreType;
      lane_q <= bus.EX_MEM_Addr[1:0];
    end
  end

  // Strobes track the state being entered, so they are high during that state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Mem_Read      <= 1'b0;
      bus.Mem_Write     <= 1'b0;
      bus.StoreDone     <= 1'b0;
      bus.Mem_Addr      <= 32'h0000_0000;
      bus.Mem_WriteData <= 32'h0000_0000;
    end else begin
      bus.Mem_Read  <= (next_state == READ);
      bus.Mem_Write <= (next_state == WRITE);
      bus.StoreDone <= (next_state == DONE);
      if (accept) begin
        bus.Mem_Addr      <= word_addr(bus.EX_MEM_Addr);
        bus.Mem_WriteData <= bus.EX_MEM_WriteData;
      end else if (state == MERGE) begin
        bus.Mem_WriteData <= merged;
      end
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit with a behavioural word RAM and a
// byte-level reference model of the store rules.
module tb_store_merge_unit;
  import store_merge_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_merge_unit_if bus();
  store_merge_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [1024];
  logic [31:0] env_mem [1024];
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  logic [31:0] rd_data_q = 32'h0;
  logic        init_en = 1'b0;
  logic        preload_en = 1'b0;
  logic [9:0]  preload_idx = 10'd0;
  logic [31:0] preload_val = 32'h0;
  logic [31:0] mon_a, mon_d;

  assign bus.Mem_ReadData = rd_data_q;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] iv;
    iv = i;
    return (iv * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  // Reference: apply the store to the old word as four independent bytes
  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] rt,
                                            input logic [3:0] t, input logic [1:0] a);
    logic [7:0] b [4];
    int base;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    if (t == 4'h8) return rt;
    if (t == 4'h9) b[a] = rt[7:0];
    if (t == 4'hA) begin
      base = (a >= 2'd2) ? 2 : 0;
      b[base] = rt[7:0];
      b[base+1] = rt[15:8];
    end
    if (t == 4'hB) begin b[3] = rt[31:24]; b[2] = rt[23:16]; end
    if (t == 4'hC) begin b[1] = rt[15:8]; b[0] = rt[7:0]; end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic bit tb_legal(input logic [3:0] t);
    return (t >= 4'h8) && (t <= 4'hC);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural word RAM: one-cycle read latency, whole-word writes
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 1024; i++) env_mem[i] <= init_word(i);
    end else if (preload_en) begin
      env_mem[preload_idx] <= preload_val;
    end else if (bus.Mem_Write) begin
      env_mem[bus.Mem_Addr[11:2]] <= bus.Mem_WriteData;
    end
    if (bus.Mem_Read) rd_data_q <= env_mem[bus.Mem_Addr[11:2]];
  end

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && bus.Mem_Write) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 bus.Mem_Addr, bus.Mem_WriteData);
      end else begin
        mon_a = exp_addr_q.pop_front();
        mon_d = exp_data_q.pop_front();
        check("write_addr", bus.Mem_Addr, mon_a);
        check("write_data", bus.Mem_WriteData, mon_d);
      end
    end
  end

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    preload_en  = 1'b1;
    preload_idx = addr[11:2];
    preload_val = val;
    @(negedge clk);
    preload_en = 1'b0;
    ref_mem[addr[11:2]] = val;
  endtask

  task automatic do_store(input logic [3:0] t, input logic [31:0] addr,
                          input logic [31:0] rt, input bit scramble);
    bit legal, sub, done;
    int exp_done, wr_cyc, rd_cyc;
    logic [31:0] waddr;
    legal    = tb_legal(t);
    sub      = legal && (t != 4'h8);
    exp_done = !legal ? 1 : (sub ? 4 : 2);
    wr_cyc   = sub ? 3 : (legal ? 1 : -1);
    rd_cyc   = sub ? 1 : -1;
    waddr    = {addr[31:2], 2'b00};
    if (legal) begin
      ref_mem[addr[11:2]] = ref_store(ref_mem[addr[11:2]], rt, t, addr[1:0]);
      exp_addr_q.push_back(waddr);
      exp_data_q.push_back(ref_mem[addr[11:2]]);
    end
    @(negedge clk);
    bus.EX_MEM_MemWrite  = 1'b1;
    bus.EX_MEM_StoreType = t;
    bus.EX_MEM_Addr      = addr;
    bus.EX_MEM_WriteData = rt;
    #1;
    check("stall_accept", bus.StoreStall, 32'd1);
    done = 1'b0;
    for (int k = 1; k <= exp_done; k++) begin
      @(negedge clk);
      if (scramble && k == 1) begin
        bus.EX_MEM_MemWrite  = 1'b0;
        bus.EX_MEM_StoreType = 4'($urandom);
        bus.EX_MEM_Addr      = $urandom;
        bus.EX_MEM_WriteData = $urandom;
      end
      #1;
      check("mem_read_strobe", bus.Mem_Read, (k == rd_cyc) ? 32'd1 : 32'd0);
      check("mem_write_strobe", bus.Mem_Write, (k == wr_cyc) ? 32'd1 : 32'd0);
      check("mem_addr_hold", bus.Mem_Addr, waddr);
      if (k == exp_done) begin
        check("store_done", bus.StoreDone, 32'd1);
        check("stall_in_done", bus.StoreStall, 32'd0);
        bus.EX_MEM_MemWrite = 1'b0;
      end else begin
        check("done_early", bus.StoreDone, 32'd0);
        check("stall_busy", bus.StoreStall, 32'd1);
      end
    end
  endtask

  initial begin
    int mism;
    logic [3:0] types [6];
    logic [3:0] t;
    types = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    rst = 1'b1;
    bus.EX_MEM_MemWrite  = 1'b0;
    bus.EX_MEM_StoreType = 4'h0;
    bus.EX_MEM_Addr      = 32'h0;
    bus.EX_MEM_WriteData = 32'h0;
    init_en = 1'b1;
    repeat (2) @(negedge clk);
    init_en = 1'b0;
    check("reset_stall", bus.StoreStall, 32'd0);
    check("reset_done", bus.StoreDone, 32'd0);
    check("reset_read", bus.Mem_Read, 32'd0);
    check("reset_write", bus.Mem_Write, 32'd0);
    check("reset_addr", bus.Mem_Addr, 32'd0);
    check("reset_wdata", bus.Mem_WriteData, 32'd0);
    rst = 1'b0;

    // Directed cases
    do_store(Type_SW, 32'h100, 32'hDEAD_BEEF, 1'b0);
    set_word(32'h100, 32'h1122_3344);
    do_store(Type_SB, 32'h102, 32'h0000_00AA, 1'b0);
    @(negedge clk);
    check("sb_word", env_mem[10'h040], 32'h11AA_3344);
    set_word(32'h200, 32'h1122_3344);
    do_store(Type_SH, 32'h203, 32'h0000_BEEF, 1'b0);
    @(negedge clk);
    check("sh_word", env_mem[10'h080], 32'hBEEF_3344);
    set_word(32'h200, 32'h1122_3344);
    do_store(Type_SWL, 32'h200, 32'hCAFE_0000, 1'b0);
    @(negedge clk);
    check("swl_word", env_mem[10'h080], 32'hCAFE_3344);
    set_word(32'h200, 32'h1122_3344);
    do_store(Type_SWR, 32'h200, 32'h0000_F00D, 1'b0);
    @(negedge clk);
    check("swr_word", env_mem[10'h080], 32'h1122_F00D);

    // Back-to-back byte stores into the same word
    set_word(32'h140, 32'h0000_0000);
    do_store(Type_SB, 32'h140, 32'h0000_0055, 1'b0);
    do_store(Type_SB, 32'h143, 32'h0000_0066, 1'b0);
    @(negedge clk);
    check("b2b_word", env_mem[10'h050], 32'h6600_0055);

    do_store(4'hF, 32'h180, 32'h1234_5678, 1'b0);

    // Reset while the read-modify-write sits in MERGE
    @(negedge clk);
    bus.EX_MEM_MemWrite  = 1'b1;
    bus.EX_MEM_StoreType = Type_SB;
    bus.EX_MEM_Addr      = 32'h300;
    bus.EX_MEM_WriteData = 32'h0000_0077;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    bus.EX_MEM_MemWrite = 1'b0;
    #1;
    check("rst_stall", bus.StoreStall, 32'd0);
    check("rst_read", bus.Mem_Read, 32'd0);
    check("rst_write", bus.Mem_Write, 32'd0);
    check("rst_done", bus.StoreDone, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mem_unchanged", env_mem[10'h0C0], ref_mem[10'h0C0]);

    // Randomized stores, with occasional idle gaps and input scrambling
    for (int n = 0; n < 200; n++) begin
      t = types[$urandom_range(0, 5)];
      do_store(t, 32'($urandom_range(0, 4095)), $urandom, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("pending_writes", exp_addr_q.size(), 32'd0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (env_mem[i] !== ref_mem[i]) mism++;
    check("final_mem_mismatches", mism, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
